// File: rtl/svm_pkg.sv
// svm_pkg: shared SVM widths, width derivation and the saturating resize.
package svm_pkg;
  localparam int CWIDTH_DEF = 9;
  localparam int FWIDTH_DEF = 8;
  localparam int STAGE_DEF = 32;
  localparam int AWIDTH_DEF = 24;
  function automatic int pwidth(input int c, input int f);
    return c + f + 1;
  endfunction
  function automatic int iwidth(input int c, input int f, input int st);
    return c + f + 1 + $clog2(st) + 1;
  endfunction
  function automatic logic signed [63:0] sat_resize(input logic signed [63:0] v, input int aw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/svmac_if.sv
// svmac_if: beat stream in, decision score out.
interface svmac_if #(parameter int CWIDTH = 9, parameter int FWIDTH = 8, parameter int AWIDTH = 24);
  logic dv, sof;
  logic signed [CWIDTH-1:0] svcoeff;
  logic [FWIDTH-1:0] feature;
  logic signed [AWIDTH-1:0] bias;
  logic signed [AWIDTH-1:0] score_out;
  logic class_out, score_dv, busy;
  modport master(output dv, sof, svcoeff, feature, bias, input score_out, class_out, score_dv, busy);
  modport slave(input dv, sof, svcoeff, feature, bias, output score_out, class_out, score_dv, busy);
endinterface

// File: rtl/svmac_svsat.sv
// svmac_svsat: adds the bias to the accumulated sum and clamps to the score width.
module svsat import svm_pkg::*; #(parameter int IWIDTH = 24, parameter int AWIDTH = 24) (
  input logic signed [IWIDTH-1:0] acc,
  input logic signed [AWIDTH-1:0] bias,
  output logic signed [AWIDTH-1:0] score
);
  logic signed [63:0] sum;
  assign sum = 64'(acc) + 64'(bias);
  assign score = AWIDTH'(sat_resize(sum, AWIDTH));
endmodule

// File: rtl/svmac.sv
// svmac: three-stage multiply-accumulate over STAGE-beat vectors, bias add and saturated score.
module svmac import svm_pkg::*; #(
  parameter int CWIDTH = CWIDTH_DEF,
  parameter int FWIDTH = FWIDTH_DEF,
  parameter int STAGE = STAGE_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input logic clk,
  input logic reset_n,
  svmac_if.slave s
);
  localparam int PWIDTH = pwidth(CWIDTH, FWIDTH);
  localparam int CNTW = $clog2(STAGE);
  localparam int IWIDTH = iwidth(CWIDTH, FWIDTH, STAGE);
  logic [CNTW-1:0] cnt, idx;
  logic last, p_first, p_last, p_dv, a_last, class_r, score_dv_r;
  logic signed [PWIDTH-1:0] prod;
  logic signed [IWIDTH-1:0] acc, prod_x;
  logic signed [AWIDTH-1:0] sat, score_r;
  assign idx = s.sof ? '0 : cnt;
  assign last = idx == CNTW'(STAGE - 1);
  assign prod_x = {{(IWIDTH-PWIDTH){prod[PWIDTH-1]}}, prod};
  svsat #(.IWIDTH(IWIDTH), .AWIDTH(AWIDTH)) u_sat (.acc(acc), .bias(s.bias), .score(sat));
  // a_last is a pulse so each completed vector strobes exactly once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      prod <= '0;
      p_first <= 1'b0;
      p_last <= 1'b0;
      p_dv <= 1'b0;
      acc <= '0;
      a_last <= 1'b0;
      score_r <= '0;
      class_r <= 1'b0;
      score_dv_r <= 1'b0;
    end else begin
      if (s.dv) begin
        cnt <= last ? '0 : idx + 1'b1;
        prod <= $signed(s.svcoeff) * $signed({1'b0, s.feature});
        p_first <= idx == '0;
        p_last <= last;
      end
      p_dv <= s.dv;
      if (p_dv) acc <= p_first ? prod_x : acc + prod_x;
      a_last <= p_dv & p_last;
      if (a_last) begin
        score_r <= sat;
        class_r <= ~sat[AWIDTH-1];
      end
      score_dv_r <= a_last;
    end
  end
  assign s.score_out = score_r;
  assign s.class_out = class_r;
  assign s.score_dv = score_dv_r;
  assign s.busy = (cnt != '0) | p_dv | a_last;
endmodule

// File: tb/tb_svmac.sv
// tb_svmac: directed vectors with a queued scoreboard per DUT instance.
module tb_svmac;
  typedef struct {int score; bit cls;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  int strobe_cyc = -1, prev_strobe = -1;
  exp_t qa[$], qb[$], qc[$];
  svmac_if #(.CWIDTH(9), .FWIDTH(8), .AWIDTH(24)) ia();
  svmac_if #(.CWIDTH(9), .FWIDTH(8), .AWIDTH(24)) ib();
  svmac_if #(.CWIDTH(9), .FWIDTH(8), .AWIDTH(16)) ic();
  svmac #(.STAGE(4), .AWIDTH(24)) dut_a (.clk(clk), .reset_n(rst_n), .s(ia.slave));
  svmac #(.STAGE(32), .AWIDTH(24)) dut_b (.clk(clk), .reset_n(rst_n), .s(ib.slave));
  svmac #(.STAGE(32), .AWIDTH(16)) dut_c (.clk(clk), .reset_n(rst_n), .s(ic.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic pop_cmp(input string n, inout exp_t q[$], input int sc, input bit cl);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected strobe: got score %0d class %0d expected none", n, sc, cl);
    end else begin
      e = q.pop_front();
      if (sc != e.score || cl != e.cls) begin
        errors++;
        $display("FAIL %s score: got %0d/%0d expected %0d/%0d", n, sc, cl, e.score, e.cls);
      end
    end
  endtask
  always @(negedge clk) if (ia.score_dv) begin
    prev_strobe = strobe_cyc;
    strobe_cyc = cyc;
    pop_cmp("a", qa, int'(ia.score_out), ia.class_out);
  end
  always @(negedge clk) if (ib.score_dv) pop_cmp("b", qb, int'(ib.score_out), ib.class_out);
  always @(negedge clk) if (ic.score_dv) pop_cmp("c", qc, int'(ic.score_out), ic.class_out);
  task automatic a_beat(input int c, input int f, input bit sof);
    ia.dv = 1'b1;
    ia.sof = sof;
    ia.svcoeff = 9'(c);
    ia.feature = 8'(f);
    @(negedge clk);
    ia.dv = 1'b0;
    ia.sof = 1'b0;
    ia.svcoeff = '0;
    ia.feature = '0;
  endtask
  task automatic push_a(input int sc);
    exp_t e;
    e.score = sc;
    e.cls = sc >= 0;
    qa.push_back(e);
  endtask
  task automatic drain(input string n);
    repeat (5) @(negedge clk);
    chk(n, qa.size() + qb.size() + qc.size(), 0);
  endtask
  initial begin
    int t_last;
    exp_t e;
    {ia.dv, ia.sof, ia.svcoeff, ia.feature, ia.bias} = '0;
    {ib.dv, ib.sof, ib.svcoeff, ib.feature, ib.bias} = '0;
    {ic.dv, ic.sof, ic.svcoeff, ic.feature, ic.bias} = '0;
    repeat (2) @(negedge clk);
    chk("reset score", ia.score_out, 0);
    chk("reset busy", ia.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // contiguous vector, bias 0
    push_a(100);
    for (int i = 0; i < 4; i++) a_beat(1, 10 * (i + 1), i == 0);
    t_last = cyc;
    drain("t1 drain");
    chk("t1 latency", strobe_cyc, t_last + 2);
    // gapped vector, bias -150
    ia.bias = -24'sd150;
    push_a(-50);
    for (int i = 0; i < 4; i++) begin
      a_beat(1, 10 * (i + 1), i == 0);
      chk("t2 busy beat", ia.busy, 1);
      if (i < 3) repeat (3) begin
        @(negedge clk);
        chk("t2 busy gap", ia.busy, 1);
      end
    end
    @(negedge clk);
    chk("t2 busy tail", ia.busy, 1);
    drain("t2 drain");
    // aborted partial then full vector
    ia.bias = '0;
    push_a(40);
    a_beat(7, 9, 1'b1);
    a_beat(7, 9, 1'b0);
    for (int i = 0; i < 4; i++) a_beat(2, 5, i == 0);
    drain("t4 drain");
    // back-to-back vectors, second delimited by count
    push_a(10);
    push_a(-10);
    for (int i = 0; i < 4; i++) a_beat(1, i + 1, i == 0);
    for (int i = 0; i < 4; i++) a_beat(-1, i + 1, 1'b0);
    drain("t5 drain");
    chk("t5 spacing", strobe_cyc - prev_strobe, 4);
    // reset mid-vector
    a_beat(3, 3, 1'b1);
    a_beat(3, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6 score", ia.score_out, 0);
    chk("t6 class", ia.class_out, 0);
    chk("t6 dv", ia.score_dv, 0);
    chk("t6 busy", ia.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_a(100);
    for (int i = 0; i < 4; i++) a_beat(1, 10 * (i + 1), i == 0);
    drain("t6 drain");
    // full-width defaults and 16-bit saturation
    ib.bias = -24'sd1;
    ic.bias = -16'sd1;
    for (int v = 0; v < 2; v++) begin
      e.score = v == 0 ? -2088961 : 2080799;
      e.cls = v == 1;
      qb.push_back(e);
      e.score = v == 0 ? -32768 : 32767;
      qc.push_back(e);
      for (int i = 0; i < 32; i++) begin
        ib.dv = 1'b1;
        ic.dv = 1'b1;
        ib.sof = i == 0;
        ic.sof = i == 0;
        ib.svcoeff = v == 0 ? -9'sd256 : 9'sd255;
        ic.svcoeff = ib.svcoeff;
        ib.feature = 8'd255;
        ic.feature = 8'd255;
        @(negedge clk);
      end
    end
    {ib.dv, ib.sof, ib.svcoeff, ib.feature} = '0;
    {ic.dv, ic.sof, ic.svcoeff, ic.feature} = '0;
    drain("wide drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
